// File: rtl/regfile_dump_pkg.sv
// Shared constants for the 32x32 register file and the dump FSM state encoding.
package regfile_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_NUM    = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_DONE = 3'd3,
    ST_CSUM = 3'd4
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// Output beat stream of the register dump: (addr, data, last) qualified by valid/ready.
// A beat transfers on a rising edge where valid && ready; once valid rises, addr/data/last
// hold stable and valid stays high until that transfer happens.
interface regfile_dump_if #(
  parameter int ADDR_W = regfile_dump_pkg::REG_ADDR_W,
  parameter int DATA_W = regfile_dump_pkg::REG_DATA_W
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output addr, output data, output last, input ready);
  modport slave  (input valid, input addr, input data, input last, output ready);
endinterface

// File: rtl/regfile_dump_csum.sv
// XOR accumulator over captured words; only built when REGDUMP_CSUM_EN is defined.
`ifdef REGDUMP_CSUM_EN
module regdump_csum
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_word,
  output logic [DATA_W-1:0] o_acc
);
  logic [DATA_W-1:0] r_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_word;
    end
  end

  assign o_acc = r_acc;
endmodule
`endif

// File: rtl/regfile_dump.sv
// Walks register-file read port 2 over addresses 0..NUM_REGS-1 and streams (addr, data) beats.
// Optional trailing XOR checksum beat when REGDUMP_CSUM_EN is defined.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic [ADDR_W-1:0]  o_raddr,
  input  logic [DATA_W-1:0]  i_rdata,
  regfile_dump_if.master     m_beat,
  output dump_state_e        o_state
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e       r_state;
  dump_state_e       w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_valid;
  logic              w_last;
  logic              w_hs;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  assign w_hs = w_valid && m_beat.ready;

`ifdef REGDUMP_CSUM_EN
  logic [DATA_W-1:0] w_acc;

  regdump_csum #(.DATA_W(DATA_W)) u_csum (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  ((r_state == ST_IDLE) && i_start),
    .i_en   (r_state == ST_READ),
    .i_word (i_rdata),
    .o_acc  (w_acc)
  );
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_READ;
      ST_READ: w_next = ST_SEND;
      ST_SEND: begin
        if (w_hs) begin
          if (r_idx == LAST_IDX) begin
`ifdef REGDUMP_CSUM_EN
            w_next = ST_CSUM;
`else
            w_next = ST_DONE;
`endif
          end else begin
            w_next = ST_READ;
          end
        end
      end
`ifdef REGDUMP_CSUM_EN
      ST_CSUM: if (w_hs) w_next = ST_DONE;
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Terminal compare precedes the increment, so idx never wraps past LAST_IDX.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) r_idx <= '0;
        ST_READ: begin
          r_addr <= r_idx;
          r_data <= i_rdata;
        end
        ST_SEND: if (w_hs && (r_idx != LAST_IDX)) r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy  = (r_state != ST_IDLE);
    o_done  = (r_state == ST_DONE);
    o_raddr = (r_state == ST_READ) ? r_idx : '0;
    w_valid = (r_state == ST_SEND);
    w_addr  = r_addr;
    w_data  = r_data;
`ifdef REGDUMP_CSUM_EN
    w_last  = (r_state == ST_CSUM);
    if (r_state == ST_CSUM) begin
      w_valid = 1'b1;
      w_addr  = '0;
      w_data  = w_acc;
    end
`else
    w_last  = (r_state == ST_SEND) && (r_addr == LAST_IDX);
`endif
  end

  assign m_beat.valid = w_valid;
  assign m_beat.addr  = w_addr;
  assign m_beat.data  = w_data;
  assign m_beat.last  = w_last;
  assign o_state      = r_state;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: register-file model, table of dump scenarios,
// directed timing / reset sequences, and a beat scoreboard.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

`ifdef REGDUMP_CSUM_EN
  localparam int NB = REG_NUM + 1;
`else
  localparam int NB = REG_NUM;
`endif
  localparam int BW = 1 + REG_ADDR_W + REG_DATA_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  busy, done;
  logic [REG_ADDR_W-1:0] raddr;
  logic [REG_DATA_W-1:0] rdata;
  dump_state_e           state;
  logic [REG_DATA_W-1:0] regs [REG_NUM];

  regfile_dump_if beat_if ();

  regfile_dump dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .o_raddr (raddr),
    .i_rdata (rdata),
    .m_beat  (beat_if),
    .o_state (state)
  );

  // Register file model: r0 is hardwired to zero.
  assign rdata = (raddr == '0) ? '0 : regs[raddr];

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int beats   = 0;
  int dones   = 0;
  logic [BW-1:0] exp_q[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard: every accepted beat is compared against the head of exp_q.
  always @(negedge clk) begin
    if (!rst) begin
      if (beat_if.valid && beat_if.ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(beat_if.addr), 64'hFFFF);
        end else begin
          check("beat", 64'({beat_if.last, beat_if.addr, beat_if.data}), 64'(exp_q.pop_front()));
        end
      end
      if (done) dones++;
    end
  end

  task automatic preload();
    for (int i = 0; i < REG_NUM; i++) regs[i] = 32'h1000_0000 + i;
  endtask

  task automatic push_expected(input bit wr20);
    logic [REG_DATA_W-1:0] d;
    logic [REG_DATA_W-1:0] acc;
    logic                  l;
    acc = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (i == 0) d = '0;
      else if (wr20 && i == 20) d = 32'hDEAD_BEEF;
      else d = 32'h1000_0000 + i;
      acc ^= d;
`ifdef REGDUMP_CSUM_EN
      l = 1'b0;
`else
      l = (i == REG_NUM - 1);
`endif
      exp_q.push_back({l, REG_ADDR_W'(i), d});
    end
`ifdef REGDUMP_CSUM_EN
    exp_q.push_back({1'b1, REG_ADDR_W'(0), acc});
`endif
  endtask

  task automatic run_dump(input int stall_beat, input int stall_cyc, input int poke_beat,
                          input bit rnd, input bit wr20);
    int cycles;
    int stalled;
    bit poked;
    preload();
    push_expected(wr20);
    beats = 0; dones = 0; stalled = 0; poked = 0; cycles = 0;
    @(posedge clk); #1; start = 1'b1; beat_if.ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (dones == 0 && cycles < 2000) begin
      start = 1'b0;
      if (rnd) beat_if.ready = 1'($urandom_range(0, 1));
      else if (beat_if.valid && beats == stall_beat && stalled < stall_cyc) begin
        beat_if.ready = 1'b0;
        stalled++;
        check("stall_valid", 64'(beat_if.valid), 64'd1);
        check("stall_addr", 64'(beat_if.addr), 64'(stall_beat));
        check("stall_data", 64'(beat_if.data), 64'h1000_0000 + 64'(stall_beat));
      end else beat_if.ready = 1'b1;
      if (poke_beat >= 0 && beat_if.valid && beats == poke_beat && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (poke_beat >= 0 && done) start = 1'b1;
      if (wr20 && beat_if.valid && beats == 19) regs[20] = 32'hDEAD_BEEF;
      @(posedge clk); #1; cycles++;
    end
    start = 1'b0;
    beat_if.ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string name;
    int    stall_beat;
    int    stall_cyc;
    int    poke_beat;
    bit    rnd;
    bit    wr20;
    int    exp_beats;
    int    exp_dones;
  } vec_t;

  vec_t vecs [5];

  initial begin
    beat_if.ready = 1'b1;
    preload();
    vecs[0] = '{"plain",      -1, 0, -1, 1'b0, 1'b0, NB, 1};
    vecs[1] = '{"stall7",      7, 3, -1, 1'b0, 1'b0, NB, 1};
    vecs[2] = '{"poke4",      -1, 0,  4, 1'b0, 1'b0, NB, 1};
    vecs[3] = '{"write20",    -1, 0, -1, 1'b0, 1'b1, NB, 1};
    vecs[4] = '{"rand_ready", -1, 0, -1, 1'b1, 1'b0, NB, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_valid", 64'(beat_if.valid), 64'd0);
    check("rst_raddr", 64'(raddr), 64'd0);
    check("rst_addr",  64'(beat_if.addr), 64'd0);
    check("rst_data",  64'(beat_if.data), 64'd0);
    check("rst_state", 64'(state), 64'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed cycle timing with ready held high.
    push_expected(1'b0);
    beats = 0; dones = 0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;                      // edge E
    check("t_e_busy",  64'(busy), 64'd1);
    check("t_e_state", 64'(state), 64'(ST_READ));
    check("t_e_raddr", 64'(raddr), 64'd0);
    check("t_e_valid", 64'(beat_if.valid), 64'd0);
    @(posedge clk); #1;                                    // E+1
    check("t_b0_valid", 64'(beat_if.valid), 64'd1);
    check("t_b0_addr",  64'(beat_if.addr), 64'd0);
    check("t_b0_data",  64'(beat_if.data), 64'd0);
    @(posedge clk); #1;                                    // E+2
    check("t_r1_raddr", 64'(raddr), 64'd1);
    check("t_r1_state", 64'(state), 64'(ST_READ));
    repeat (2 * NB - 3) @(posedge clk);
    #1;                                                    // E+2NB-1
    check("t_lastbeat_last", 64'(beat_if.last), 64'd1);
    check("t_lastbeat_done", 64'(done), 64'd0);
    @(posedge clk); #1;                                    // E+2NB
    check("t_done_pulse", 64'(done), 64'd1);
    check("t_done_busy",  64'(busy), 64'd1);
    check("t_done_valid", 64'(beat_if.valid), 64'd0);
    @(posedge clk); #1;
    check("t_after_done", 64'(done), 64'd0);
    check("t_after_busy", 64'(busy), 64'd0);
    check("t_beats", 64'(beats), 64'(NB));
    check("t_dones", 64'(dones), 64'd1);
    check("t_q_empty", 64'(exp_q.size()), 64'd0);

    for (int v = 0; v < 5; v++) begin
      run_dump(vecs[v].stall_beat, vecs[v].stall_cyc, vecs[v].poke_beat, vecs[v].rnd, vecs[v].wr20);
      check({vecs[v].name, "_beats"}, 64'(beats), 64'(vecs[v].exp_beats));
      check({vecs[v].name, "_dones"}, 64'(dones), 64'(vecs[v].exp_dones));
      check({vecs[v].name, "_q_empty"}, 64'(exp_q.size()), 64'd0);
      check({vecs[v].name, "_idle"}, 64'(busy), 64'd0);
      exp_q.delete();
    end

    // Asynchronous reset during beat 10, then a clean restart.
    preload();
    push_expected(1'b0);
    beats = 0; dones = 0;
    beat_if.ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 200 && !(beat_if.valid && beat_if.addr == 5'd10); c++) begin
      @(posedge clk); #1;
    end
    check("rm_reached_b10", 64'(beat_if.addr), 64'd10);
    #2 rst = 1'b1;
    #1;
    check("rm_valid", 64'(beat_if.valid), 64'd0);
    check("rm_busy",  64'(busy), 64'd0);
    check("rm_raddr", 64'(raddr), 64'd0);
    check("rm_state", 64'(state), 64'(ST_IDLE));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rm_no_done", 64'(dones), 64'd0);
    run_dump(-1, 0, -1, 1'b0, 1'b0);
    check("rm_restart_beats", 64'(beats), 64'(NB));
    check("rm_restart_dones", 64'(dones), 64'd1);
    check("rm_restart_q", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
